prefetch_fifo_reader: RTL and testbench

Read-side consumer for the 8-bit prefetch (first-word-fall-through) FIFOs in the video path. It drains bytes via the FIFO's rd_en/rd_vld/rd_data handshake and packs them into 32-bit words. It presents those words on a valid/ready stream toward the DDR write/burst logic, tagging the last word of each fixed-length burst. It sits in the FIFO's read clock domain.

---
 rtl/prefetch_fifo_reader.sv | 145 ++++++++++++++
 tb/tb_prefetch_fifo_reader.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/prefetch_fifo_reader.sv
// prefetch_fifo_reader: packs prefetch-FIFO bytes into words on a valid/ready burst stream.
// Define PREFETCH_FIFO_READER_TIMEOUT_EN to flush idle partial words after TIMEOUT_CYCLES.
module prefetch_fifo_reader #(
   parameter int BYTES_PER_WORD = 4,
   parameter int BURST_LEN      = 16,
   parameter bit LITTLE_ENDIAN  = 1,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                        rd_clk,
   input  logic                        rd_rst_n,
   input  logic                        fifo_vld,
   input  logic [7:0]                  fifo_data,
   output logic                        fifo_rd_en,
   output logic                        m_valid,
   input  logic                        m_ready,
   output logic [8*BYTES_PER_WORD-1:0] m_data,
   output logic [BYTES_PER_WORD-1:0]   m_keep,
   output logic                        m_last,
   output logic [7:0]                  burst_cnt
);
   localparam int IW = $clog2(BYTES_PER_WORD + 1);
   localparam int LW = $clog2(BYTES_PER_WORD);
   localparam logic [IW-1:0] LAST_IDX = IW'(BYTES_PER_WORD - 1);
   localparam logic [LW-1:0] LAST_LANE = LW'(BYTES_PER_WORD - 1);
   localparam logic [7:0] LAST_BEAT = 8'(BURST_LEN - 1);

   generate
      if (BYTES_PER_WORD < 2 || BYTES_PER_WORD > 8 || BURST_LEN < 1 || BURST_LEN > 256 ||
          TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
         $error("prefetch_fifo_reader: parameter out of range");
      end
   endgenerate

   typedef enum logic {FILL, READY} state_t;
   state_t r_state, w_state_next;

   logic [IW-1:0]                   r_byte_idx;
   logic [LW-1:0]                   w_lane;
   logic [BYTES_PER_WORD-1:0][7:0]  r_pack;
   logic                            r_m_valid, r_m_last;
   logic [8*BYTES_PER_WORD-1:0]     r_m_data;
   logic [BYTES_PER_WORD-1:0]       r_m_keep, w_out_keep;
   logic [7:0]                      r_burst_cnt;
   logic w_pack_full, w_xfer, w_pop, w_word_done, w_tmo_fire, w_out_last, w_last_beat;

   assign w_pack_full = r_state == READY;
   assign w_xfer      = w_pack_full & (~r_m_valid | m_ready);
   assign w_pop       = rd_rst_n & fifo_vld & (~w_pack_full | w_xfer);
   assign w_lane      = LITTLE_ENDIAN ? r_byte_idx[LW-1:0] : LAST_LANE - r_byte_idx[LW-1:0];
   assign w_word_done = (w_pop & (r_byte_idx == LAST_IDX)) | w_tmo_fire;
   assign w_last_beat = w_out_last | (r_burst_cnt == LAST_BEAT);

`ifdef PREFETCH_FIFO_READER_TIMEOUT_EN
   logic [15:0]                     r_tmo;
   logic [BYTES_PER_WORD-1:0]       r_pack_keep, w_keep_mask;
   logic [BYTES_PER_WORD-1:0][7:0]  w_bit_mask;
   logic                            r_pack_last, w_tmo_inc;

   // a nonzero byte index only exists while filling, so no fire can collide with xfer
   assign w_tmo_inc  = (r_byte_idx != '0) & ~w_pop;
   assign w_tmo_fire = w_tmo_inc & (r_tmo == 16'(TIMEOUT_CYCLES - 1));
   assign w_out_keep = r_pack_keep;
   assign w_out_last = r_pack_last;

   always_comb begin
      w_keep_mask = '0;
      w_bit_mask  = '0;
      for (int i = 0; i < BYTES_PER_WORD; i++) begin
         w_keep_mask[i] = LITTLE_ENDIAN ? (i < int'(r_byte_idx)) : (BYTES_PER_WORD - 1 - i < int'(r_byte_idx));
         w_bit_mask[i]  = {8{w_keep_mask[i]}};
      end
   end

   always_ff @(posedge rd_clk) begin
      if (!rd_rst_n) begin
         r_tmo       <= '0;
         r_pack_keep <= '0;
         r_pack_last <= 1'b0;
      end else begin
         r_tmo <= (!w_tmo_inc || w_tmo_fire) ? '0 : r_tmo + 16'd1;
         if (w_tmo_fire) begin
            r_pack_keep <= w_keep_mask;
            r_pack_last <= 1'b1;
         end else if (w_word_done) begin
            r_pack_keep <= '1;
            r_pack_last <= 1'b0;
         end
      end
   end
`else
   assign w_tmo_fire = 1'b0;
   assign w_out_keep = '1;
   assign w_out_last = 1'b0;
`endif

   always_comb begin
      w_state_next = r_state;
      if (w_word_done) w_state_next = READY;
      else if (w_xfer) w_state_next = FILL;
   end

   always_ff @(posedge rd_clk) begin
      if (!rd_rst_n) r_state <= FILL;
      else r_state <= w_state_next;
   end

   always_ff @(posedge rd_clk) begin
      if (!rd_rst_n) begin
         r_byte_idx  <= '0;
         r_pack      <= '0;
         r_m_valid   <= 1'b0;
         r_m_data    <= '0;
         r_m_keep    <= '0;
         r_m_last    <= 1'b0;
         r_burst_cnt <= '0;
      end else begin
         if (w_pop) begin
            r_pack[w_lane] <= fifo_data;
            r_byte_idx     <= (r_byte_idx == LAST_IDX) ? '0 : r_byte_idx + 1'b1;
         end
`ifdef PREFETCH_FIFO_READER_TIMEOUT_EN
         else if (w_tmo_fire) begin
            r_pack     <= r_pack & w_bit_mask;
            r_byte_idx <= '0;
         end
`endif
         if (w_xfer) begin
            r_m_valid   <= 1'b1;
            r_m_data    <= r_pack;
            r_m_keep    <= w_out_keep;
            r_m_last    <= w_last_beat;
            r_burst_cnt <= w_last_beat ? 8'd0 : r_burst_cnt + 8'd1;
         end else if (m_ready) begin
            r_m_valid <= 1'b0;
         end
      end
   end

   assign fifo_rd_en = w_pop;
   assign m_valid    = r_m_valid;
   assign m_data     = r_m_data;
   assign m_keep     = r_m_keep;
   assign m_last     = r_m_last;
   assign burst_cnt  = r_burst_cnt;
endmodule

// File: tb/tb_prefetch_fifo_reader.sv
// tb_prefetch_fifo_reader: directed vectors for the byte-to-word packer, little- and big-endian instances.
module tb_prefetch_fifo_reader;
   logic rd_clk = 1'b0, rd_rst_n = 1'b0, fifo_vld = 1'b0, m_ready = 1'b0;
   logic [7:0] fifo_data = 8'h00;
   logic fifo_rd_en, m_valid, m_last, be_rd_en, be_valid, be_last;
   logic [31:0] m_data, be_data;
   logic [3:0] m_keep, be_keep;
   logic [7:0] burst_cnt, be_burst;
   int n_cmp = 0, n_bad = 0;

   prefetch_fifo_reader #(.BYTES_PER_WORD(4), .BURST_LEN(16), .LITTLE_ENDIAN(1), .TIMEOUT_CYCLES(8)) u_dut (
      .rd_clk(rd_clk), .rd_rst_n(rd_rst_n), .fifo_vld(fifo_vld), .fifo_data(fifo_data),
      .fifo_rd_en(fifo_rd_en), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
      .m_keep(m_keep), .m_last(m_last), .burst_cnt(burst_cnt));

   prefetch_fifo_reader #(.BYTES_PER_WORD(4), .BURST_LEN(16), .LITTLE_ENDIAN(0), .TIMEOUT_CYCLES(8)) u_dut_be (
      .rd_clk(rd_clk), .rd_rst_n(rd_rst_n), .fifo_vld(fifo_vld), .fifo_data(fifo_data),
      .fifo_rd_en(be_rd_en), .m_valid(be_valid), .m_ready(m_ready), .m_data(be_data),
      .m_keep(be_keep), .m_last(be_last), .burst_cnt(be_burst));

   always #5 rd_clk = ~rd_clk;

   typedef struct {
      logic vld; logic [7:0] data; logic ready;
      logic rd_en; logic valid; logic [31:0] le; logic [31:0] be; logic [3:0] keep; logic last; logic [7:0] burst;
   } vec_t;
   vec_t tbl[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic do_reset;
      rd_rst_n = 1'b0; fifo_vld = 1'b0; m_ready = 1'b1;
      @(negedge rd_clk);
      rd_rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int sent, words, gaps;
      logic [7:0] b;
      tbl[0] = '{1'b1, 8'h11, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 8'd0};
      tbl[1] = '{1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 8'd0};
      tbl[2] = '{1'b1, 8'h33, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 8'd0};
      tbl[3] = '{1'b1, 8'h44, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 8'd0};
      tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 8'd0};
      tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 32'h44332211, 32'h11223344, 4'hF, 1'b0, 8'd1};
      tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 8'd0};
      tbl[7] = '{1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 8'd0};

      // reset: pop strobe gated, all outputs cleared
      @(negedge rd_clk);
      rd_rst_n = 1'b0; fifo_vld = 1'b1; fifo_data = 8'h5A; m_ready = 1'b1;
      #1 check("rst_rd_en_gated", fifo_rd_en, 0);
      @(negedge rd_clk); #1;
      check("rst_valid", m_valid, 0);
      check("rst_data", m_data, 0);
      check("rst_keep", m_keep, 0);
      check("rst_last", m_last, 0);
      check("rst_burst", burst_cnt, 0);
      check("rst_rd_en_held", fifo_rd_en, 0);
      @(negedge rd_clk);
      rd_rst_n = 1'b1;

      // first word, both byte orders, exact latency
      for (int i = 0; i < 8; i++) begin
         fifo_vld = tbl[i].vld; fifo_data = tbl[i].data; m_ready = tbl[i].ready;
         #1;
         check($sformatf("t1_rd_en[%0d]", i), fifo_rd_en, tbl[i].rd_en);
         check($sformatf("t1_valid[%0d]", i), m_valid, tbl[i].valid);
         if (tbl[i].valid) begin
            check($sformatf("t1_data[%0d]", i), m_data, tbl[i].le);
            check($sformatf("t4_be_data[%0d]", i), be_data, tbl[i].be);
            check($sformatf("t1_keep[%0d]", i), m_keep, tbl[i].keep);
            check($sformatf("t1_last[%0d]", i), m_last, tbl[i].last);
            check($sformatf("t1_burst[%0d]", i), burst_cnt, tbl[i].burst);
         end
         @(negedge rd_clk);
      end

      // 64-byte stream: one full burst, last only on word 16
      do_reset;
      sent = 0; words = 0; gaps = 0;
      for (int c = 0; c < 200 && words < 16; c++) begin
         fifo_vld = sent < 64; fifo_data = 8'(sent);
         #1;
         if (fifo_vld && !fifo_rd_en) gaps++;
         if (fifo_rd_en) sent++;
         if (m_valid && m_ready) begin
            b = 8'(4 * words);
            check($sformatf("t2_data[%0d]", words), m_data, {b + 8'd3, b + 8'd2, b + 8'd1, b});
            check($sformatf("t2_last[%0d]", words), m_last, words == 15);
            words++;
         end
         @(negedge rd_clk);
      end
      check("t2_words", words, 16);
      check("t2_pops", sent, 64);
      check("t2_pop_gaps", gaps, 0);
      check("t2_burst_wrap", burst_cnt, 0);

      // backpressure: one output word plus one pack buffer held
      do_reset;
      m_ready = 1'b0; sent = 0;
      for (int c = 0; c < 20; c++) begin
         fifo_vld = 1'b1; fifo_data = 8'(sent);
         #1 if (fifo_rd_en) sent++;
         @(negedge rd_clk);
      end
      check("t3_pops_held", sent, 8);
      fifo_data = 8'(sent);
      #1 check("t3_stalled_rd_en", fifo_rd_en, 0);
      m_ready = 1'b1;
      words = 0;
      for (int c = 0; c < 12 && words < 2; c++) begin
         fifo_data = 8'(sent);
         #1;
         if (c == 0) check("t3_resume_rd_en", fifo_rd_en, 1);
         if (fifo_rd_en) sent++;
         if (m_valid) begin
            check($sformatf("t3_data[%0d]", words), m_data, words == 0 ? 32'h03020100 : 32'h07060504);
            words++;
         end
         @(negedge rd_clk);
      end
      check("t3_words", words, 2);

      // reset mid-word discards the partial bytes
      do_reset;
      fifo_vld = 1'b1; fifo_data = 8'hDE;
      @(negedge rd_clk);
      fifo_data = 8'hAD;
      @(negedge rd_clk);
      rd_rst_n = 1'b0; fifo_data = 8'hEE;
      #1 check("t5_rd_en_in_reset", fifo_rd_en, 0);
      @(negedge rd_clk);
      rd_rst_n = 1'b1;
      sent = 0; words = 0;
      for (int c = 0; c < 14; c++) begin
         fifo_vld = sent < 4; fifo_data = 8'(sent + 1);
         #1;
         if (fifo_rd_en) sent++;
         if (m_valid) begin
            check("t5_data", m_data, 32'h04030201);
            words++;
         end
         @(negedge rd_clk);
      end
      check("t5_words", words, 1);

`ifdef PREFETCH_FIFO_READER_TIMEOUT_EN
      // idle flush: full word, then AA BB and silence
      do_reset;
      sent = 0; words = 0;
      for (int c = 0; c < 30; c++) begin
         fifo_vld = sent < 6;
         fifo_data = sent == 4 ? 8'hAA : sent == 5 ? 8'hBB : 8'(sent);
         #1;
         if (fifo_rd_en) sent++;
         if (m_valid) begin
            if (words == 0) check("t6_first_data", m_data, 32'h03020100);
            else begin
               check("t6_flush_cycle", c, 15);
               check("t6_data", m_data, 32'h0000BBAA);
               check("t6_keep", m_keep, 4'b0011);
               check("t6_last", m_last, 1);
               check("t6_burst", burst_cnt, 0);
               check("t6_be_data", be_data, 32'hAABB0000);
               check("t6_be_keep", be_keep, 4'b1100);
            end
            words++;
         end
         @(negedge rd_clk);
      end
      check("t6_words", words, 2);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
